// File: rtl/r_fwft_out_pkg.sv
// Shared constants and types for the async FIFO read-side output stage.
package r_fwft_out_pkg;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned ADDR_SIZE = 4;
  localparam int unsigned BUF_DEPTH = 2;

  // Occupancy of the 2-entry output buffer; the encoding doubles as the count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_cnt_e;

endpackage

// File: rtl/r_fwft_out_if.sv
// Valid/ready stream carrying first-word-fall-through FIFO output words.
interface r_fwft_out_if
  import r_fwft_out_pkg::*;
#(
  parameter int unsigned DATA_SIZE = r_fwft_out_pkg::DATA_SIZE
);

  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/r_fwft_out_skid_buf.sv
// Two-entry head/tail register buffer; head is the registered output word.
module r_skid_buf
  import r_fwft_out_pkg::*;
#(
  parameter int unsigned DATA_SIZE = r_fwft_out_pkg::DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data,
  output logic [DATA_SIZE-1:0] head,
  output logic                 valid,
  output buf_cnt_e             cnt
);

  logic [DATA_SIZE-1:0] tail;
  logic [DATA_SIZE-1:0] head_nxt;
  logic [DATA_SIZE-1:0] tail_nxt;
  buf_cnt_e             cnt_nxt;

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    cnt_nxt  = cnt;
    unique case (cnt)
      BUF_EMPTY: begin
        if (push) begin
          head_nxt = data;
          cnt_nxt  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        unique case ({push, pop})
          2'b11:   head_nxt = data;
          2'b10: begin
            tail_nxt = data;
            cnt_nxt  = BUF_FULL;
          end
          2'b01:   cnt_nxt = BUF_EMPTY;
          default: ;
        endcase
      end
      BUF_FULL: begin
        // Full buffer never sees push without pop: the top throttles r_inc.
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt = data;
          else      cnt_nxt  = BUF_ONE;
        end
      end
      default: cnt_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= BUF_EMPTY;
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
    end else begin
      assert (!(cnt == BUF_FULL && push && !pop));
      cnt   <= cnt_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      valid <= (cnt_nxt != BUF_EMPTY);
    end
  end

endmodule

// File: rtl/r_fwft_out.sv
// FWFT output stage: prefetches sync-read RAM words into a 2-entry buffer,
// presenting a registered valid/ready stream at up to one word per cycle.
module r_fwft_out
  import r_fwft_out_pkg::*;
#(
  parameter int unsigned DATA_SIZE = r_fwft_out_pkg::DATA_SIZE,
  parameter int unsigned BUF_DEPTH = r_fwft_out_pkg::BUF_DEPTH
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 r_empty,
  output logic                 r_inc,
  input  logic [DATA_SIZE-1:0] r_mem_data,
  r_fwft_out_if.master         m,
  output logic [1:0]           r_buf_cnt
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("r_fwft_out supports BUF_DEPTH == 2 only");
  end

  logic     pend;
  logic     pop;
  logic     valid;
  logic [DATA_SIZE-1:0] head;
  logic [2:0] fill;
  buf_cnt_e cnt;

  assign pop  = valid & m.m_ready;
  assign fill = {1'b0, cnt} + {2'b00, pend};
  // Buffered plus in-flight words are capped at two; a pop frees one slot.
  assign r_inc = ~r_empty & ((fill < 3'd2) | pop);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      pend <= 1'b0;
    end else begin
      assert (fill <= 3'd2);
      pend <= r_inc;
    end
  end

  r_skid_buf #(.DATA_SIZE(DATA_SIZE)) u_skid_buf (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .push  (pend),
    .pop   (pop),
    .data  (r_mem_data),
    .head  (head),
    .valid (valid),
    .cnt   (cnt)
  );

  assign m.m_valid = valid;
  assign m.m_data  = head;
  assign r_buf_cnt = cnt;

endmodule

// File: tb/tb_r_fwft_out.sv
// Bench for r_fwft_out: RAM/pointer model upstream, scoreboard on the stream side.
module tb_r_fwft_out;

  logic       r_clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       r_empty;
  logic       r_inc;
  logic [7:0] r_mem_data = '0;
  logic [1:0] r_buf_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  mem [0:4095];
  int unsigned wr_cnt = 0;
  int unsigned rd_ptr = 0;
  logic [7:0]  exp_q [$];

  r_fwft_out_if #(.DATA_SIZE(8)) m_if ();

  r_fwft_out #(.DATA_SIZE(8), .BUF_DEPTH(2)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .r_empty    (r_empty),
    .r_inc      (r_inc),
    .r_mem_data (r_mem_data),
    .m          (m_if),
    .r_buf_cnt  (r_buf_cnt)
  );

  always #5 r_clk = ~r_clk;

  // Upstream model: r_empty follows the pointers, RAM reads are synchronous.
  assign r_empty = (rd_ptr == wr_cnt);

  always @(posedge r_clk) begin
    if (r_inc) begin
      r_mem_data <= mem[rd_ptr % 4096];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_word(input logic [7:0] v);
    mem[wr_cnt % 4096] = v;
    exp_q.push_back(v);
    wr_cnt++;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #2;
  endtask

  // Stream monitor: ordering, loss/duplication, stall stability, no read while empty.
  logic [7:0] prev_data;
  bit         prev_stall = 1'b0;

  always @(negedge r_clk) begin
    if (!r_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (r_empty) chk("inc_while_empty", {31'd0, r_inc}, 32'd0);
      chk("buf_cnt_le2", {31'd0, (r_buf_cnt <= 2'd2)}, 32'd1);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_if.m_valid}, 32'd1);
        chk("stall_data", {24'd0, m_if.m_data}, {24'd0, prev_data});
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_data", {24'd0, m_if.m_data}, {24'd0, exp_q.pop_front()});
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
    end
  end

  initial begin
    logic [7:0]  words [3];
    logic        exp_inc [6];
    logic        exp_val [6];
    int unsigned pulses;
    int unsigned written;
    int unsigned cycles;

    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    exp_inc[0] = 1; exp_inc[1] = 1; exp_inc[2] = 1; exp_inc[3] = 0; exp_inc[4] = 0; exp_inc[5] = 0;
    exp_val[0] = 0; exp_val[1] = 0; exp_val[2] = 1; exp_val[3] = 1; exp_val[4] = 1; exp_val[5] = 0;
    m_if.m_ready = 1'b0;

    repeat (3) tick();
    chk("rst_valid", {31'd0, m_if.m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_if.m_data}, 32'd0);
    chk("rst_cnt", {30'd0, r_buf_cnt}, 32'd0);
    chk("rst_inc", {31'd0, r_inc}, 32'd0);
    r_rst_n = 1'b1;

    // Idle with an empty FIFO.
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      chk("idle_inc", {31'd0, r_inc}, 32'd0);
      chk("idle_valid", {31'd0, m_if.m_valid}, 32'd0);
      chk("idle_cnt", {30'd0, r_buf_cnt}, 32'd0);
    end

    // Three words, consumer always ready: exact latency and throughput.
    tick();
    m_if.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) put_word(words[k]);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("lat_inc", {31'd0, r_inc}, {31'd0, exp_inc[k]});
      chk("lat_valid", {31'd0, m_if.m_valid}, {31'd0, exp_val[k]});
      if (k >= 2 && k <= 4) chk("lat_data", {24'd0, m_if.m_data}, {24'd0, words[k-2]});
      tick();
    end

    // Backpressure: only two reads issue, head holds, then drains gap-free.
    m_if.m_ready = 1'b0;
    for (int k = 0; k < 3; k++) put_word(words[k]);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      pulses += r_inc;
      tick();
    end
    chk("stall_inc_pulses", pulses, 32'd2);
    #1;
    chk("stall_cnt", {30'd0, r_buf_cnt}, 32'd2);
    chk("stall_head", {24'd0, m_if.m_data}, 32'hA1);
    m_if.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_valid", {31'd0, m_if.m_valid}, 32'd1);
      chk("drain_data", {24'd0, m_if.m_data}, {24'd0, words[k]});
      tick(); #1;
    end
    chk("drain_done", {31'd0, m_if.m_valid}, 32'd0);
    tick();

    // Random traffic and random backpressure.
    written = 0;
    cycles  = 0;
    while ((written < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      m_if.m_ready = 1'($urandom_range(0, 1));
      if (written < 1000 && $urandom_range(0, 2) != 0) begin
        put_word(8'($urandom));
        written++;
      end
      tick();
      cycles++;
    end
    chk("random_drain", exp_q.size(), 32'd0);
    chk("random_written", written, 32'd1000);

    // Async reset with a full buffer discards everything.
    m_if.m_ready = 1'b0;
    for (int k = 0; k < 3; k++) put_word(8'hB0 + 8'(k));
    repeat (4) tick();
    #1;
    chk("prerst_cnt", {30'd0, r_buf_cnt}, 32'd2);
    wr_cnt = rd_ptr;
    exp_q.delete();
    r_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, m_if.m_valid}, 32'd0);
    chk("async_rst_cnt", {30'd0, r_buf_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("in_rst_inc", {31'd0, r_inc}, 32'd0);
    end
    r_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("post_rst_inc", {31'd0, r_inc}, 32'd0);
      chk("post_rst_valid", {31'd0, m_if.m_valid}, 32'd0);
    end
    tick();
    m_if.m_ready = 1'b1;
    put_word(8'hC5);
    put_word(8'hC6);
    repeat (6) tick();
    chk("post_rst_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
